seq_game_core: RTL

- Parametrised next-generation core of the sequence-memory game.
- Supports N_BOTOES channels and a configurable round count.
- Replays an LFSR-generated sequence of growing length on the leds, then checks the player's button presses with per-level timeouts.
- Sits between the debounced button inputs and the display/HEX logic of the top-level game.

---
 rtl/seq_game_core.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/seq_game_core.sv
// Sequence-memory game core: replays an LFSR sequence of growing length on the
// leds, then checks the player's presses with a per-level idle timeout.
module seq_game_core #(
  parameter int          N_BOTOES        = 4,
  parameter int          MAX_RODADAS     = 16,
  parameter int          LED_CYCLES      = 500,
  parameter int          GAP_CYCLES      = 100,
  parameter int          TIMEOUT_FACIL   = 3000,
  parameter int          TIMEOUT_DIFICIL = 1500,
  parameter int          ALEATORIO       = 1,
  parameter logic [15:0] SEED            = 16'hACE1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           jogar,
  input  logic                           nivel,
  input  logic                           confirma,
  input  logic [N_BOTOES-1:0]            botoes,
  output logic [N_BOTOES-1:0]            leds,
  output logic                           pronto,
  output logic                           acertou,
  output logic                           errou,
  output logic                           timeout,
  output logic [$clog2(MAX_RODADAS)-1:0] rodada,
  output logic [3:0]                     estado
);
  localparam int B  = $clog2(N_BOTOES);
  localparam int RW = $clog2(MAX_RODADAS);
  localparam int M1 = (LED_CYCLES > GAP_CYCLES) ? LED_CYCLES : GAP_CYCLES;
  localparam int M2 = (TIMEOUT_FACIL > TIMEOUT_DIFICIL) ? TIMEOUT_FACIL : TIMEOUT_DIFICIL;
  localparam int CMAX = (M1 > M2) ? M1 : M2;
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [CW-1:0] LED_LAST = CW'(LED_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TF_LAST  = CW'(TIMEOUT_FACIL - 1);
  localparam logic [CW-1:0] TD_LAST  = CW'(TIMEOUT_DIFICIL - 1);
  localparam logic [RW-1:0] RD_LAST  = RW'(MAX_RODADAS - 1);
  localparam logic [RW-1:0] RF_LAST  = RW'(MAX_RODADAS / 2 - 1);

  typedef enum logic [3:0] {
    INICIAL, CONFIG, PREP_MOSTRA, MOSTRA_LED, MOSTRA_GAP, PREP_JOGA, ESPERA,
    COMPARA, ESPERA_SOLTA, PROX_RODADA, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT
  } state_t;

  state_t              state_q;
  logic [15:0]         lfsr_q, seed_q, free_q;
  logic [CW-1:0]       cnt_q;
  logic [RW-1:0]       k_q, rodada_q;
  logic                nivel_q;
  logic [N_BOTOES-1:0] leds_q;
  logic                pronto_q, acertou_q, errou_q, timeout_q;

  function automatic logic [N_BOTOES-1:0] onehot(input logic [B-1:0] e);
    onehot    = '0;
    onehot[e] = 1'b1;
  endfunction

  // x^16+x^14+x^13+x^11+1, shifted left, feedback into bit 0
  logic [15:0] lfsr_nx;
  assign lfsr_nx = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  logic [15:0] seed_raw, seed_new;
  assign seed_raw = (ALEATORIO != 0) ? (SEED ^ free_q) : SEED;
  assign seed_new = (seed_raw == 16'h0) ? 16'hACE1 : seed_raw;

  logic [N_BOTOES-1:0] exp_btn;
  logic [CW-1:0]       t_last;
  logic [RW-1:0]       r_last;
  assign exp_btn = onehot(lfsr_q[B-1:0]);
  assign t_last  = nivel_q ? TD_LAST : TF_LAST;
  assign r_last  = nivel_q ? RD_LAST : RF_LAST;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= INICIAL;
      lfsr_q    <= '0;
      seed_q    <= '0;
      free_q    <= '0;
      cnt_q     <= '0;
      k_q       <= '0;
      rodada_q  <= '0;
      nivel_q   <= 1'b0;
      leds_q    <= '0;
      pronto_q  <= 1'b0;
      acertou_q <= 1'b0;
      errou_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      free_q <= free_q + 16'd1;
      case (state_q)
        INICIAL, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
          if (jogar) begin
            state_q   <= CONFIG;
            pronto_q  <= 1'b0;
            acertou_q <= 1'b0;
            errou_q   <= 1'b0;
            timeout_q <= 1'b0;
          end
        CONFIG:
          if (confirma) begin
            nivel_q  <= nivel;
            seed_q   <= seed_new;
            rodada_q <= '0;
            state_q  <= PREP_MOSTRA;
          end
        PREP_MOSTRA: begin
          lfsr_q  <= seed_q;
          k_q     <= '0;
          cnt_q   <= '0;
          leds_q  <= onehot(seed_q[B-1:0]);
          state_q <= MOSTRA_LED;
        end
        MOSTRA_LED:
          if (cnt_q == LED_LAST) begin
            cnt_q   <= '0;
            leds_q  <= '0;
            state_q <= MOSTRA_GAP;
          end else cnt_q <= cnt_q + 1'b1;
        MOSTRA_GAP:
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            if (k_q == rodada_q) state_q <= PREP_JOGA;
            else begin
              k_q     <= k_q + 1'b1;
              lfsr_q  <= lfsr_nx;
              leds_q  <= onehot(lfsr_nx[B-1:0]);
              state_q <= MOSTRA_LED;
            end
          end else cnt_q <= cnt_q + 1'b1;
        PREP_JOGA: begin
          lfsr_q  <= seed_q;
          k_q     <= '0;
          cnt_q   <= '0;
          state_q <= ESPERA;
        end
        // a press on the last allowed cycle takes priority over the timeout
        ESPERA:
          if (botoes != '0) state_q <= COMPARA;
          else if (cnt_q == t_last) begin
            state_q   <= FIM_TIMEOUT;
            pronto_q  <= 1'b1;
            timeout_q <= 1'b1;
          end else cnt_q <= cnt_q + 1'b1;
        COMPARA: begin
          cnt_q <= '0;
          if (botoes == exp_btn) begin
            leds_q  <= botoes;
            state_q <= ESPERA_SOLTA;
          end else begin
            state_q  <= FIM_ERRO;
            pronto_q <= 1'b1;
            errou_q  <= 1'b1;
          end
        end
        ESPERA_SOLTA: begin
          cnt_q  <= '0;
          leds_q <= botoes;
          if (botoes == '0) begin
            if (k_q < rodada_q) begin
              k_q     <= k_q + 1'b1;
              lfsr_q  <= lfsr_nx;
              state_q <= ESPERA;
            end else if (rodada_q == r_last) begin
              state_q   <= FIM_ACERTO;
              pronto_q  <= 1'b1;
              acertou_q <= 1'b1;
            end else state_q <= PROX_RODADA;
          end
        end
        PROX_RODADA: begin
          if (rodada_q != r_last) rodada_q <= rodada_q + 1'b1;
          state_q <= PREP_MOSTRA;
        end
        default: state_q <= INICIAL;
      endcase
    end
  end

  assign leds    = leds_q;
  assign pronto  = pronto_q;
  assign acertou = acertou_q;
  assign errou   = errou_q;
  assign timeout = timeout_q;
  assign rodada  = rodada_q;
  assign estado  = state_q;
endmodule
